// File: rtl/cpu.sv
`default_nettype none
//============================================================================
// Module   : cpu
// Purpose  : Small accumulator CPU that fetches 16-bit instruction words
//            (and optional 16-bit immediates) from a flash handshake
//            interface and executes register, LED, UART and button ops.
// Ports    : clk             - system clock, rising edge
//            reset           - asynchronous active-high reset
//            flashReadAddr   - byte address of the word being fetched
//            flashByteRead   - word returned by flash
//            flashEnabled    - fetch request, high while waiting for a word
//            flashDataReady  - flash handshake, word valid while high
//            leds            - LED drive, active-low
//            uartData        - print payload (four ASCII hex digits of AC)
//            writeUart       - one-cycle strobe qualifying uartData
//            btn1..btn4      - push buttons, active-low
// Revision : 1.0 - initial release
//============================================================================
module cpu (
  input  logic         clk,
  input  logic         reset,
  output logic [23:0]  flashReadAddr,
  input  logic [15:0]  flashByteRead,
  output logic         flashEnabled,
  input  logic         flashDataReady,
  output logic [5:0]   leds,
  output logic [100:0] uartData,
  output logic         writeUart,
  input  logic         btn1,
  input  logic         btn2,
  input  logic         btn3,
  input  logic         btn4
);

  typedef enum logic [2:0] {
    S_FETCH        = 3'd0,
    S_WAIT_RDY     = 3'd1,
    S_WAIT_LOW     = 3'd2,
    S_DECODE       = 3'd3,
    S_FETCH_IMM    = 3'd4,
    S_WAIT_RDY_IMM = 3'd5,
    S_WAIT_LOW_IMM = 3'd6,
    S_EXEC         = 3'd7
  } state_t;

  // Register-form opcodes
  localparam logic [6:0] OP_CLR = 7'h00;
  localparam logic [6:0] OP_ADD = 7'h02;
  localparam logic [6:0] OP_STA = 7'h04;
  localparam logic [6:0] OP_INV = 7'h06;
  localparam logic [6:0] OP_LDA = 7'h08;
  localparam logic [6:0] OP_OUT = 7'h0A;
  localparam logic [6:0] OP_PRT = 7'h0C;
  localparam logic [6:0] OP_BTN = 7'h0E;
  // Immediate-form opcodes
  localparam logic [6:0] OP_ADDI = 7'h02;
  localparam logic [6:0] OP_LDI  = 7'h08;
  localparam logic [6:0] OP_JMP  = 7'h10;

  state_t      r_state;
  state_t      w_next_state;

  logic [23:0] r_pc;
  logic [23:0] r_addr;
  logic        r_flash_en;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [15:0] r_c;
  logic [15:0] r_ac;
  logic [15:0] r_ir;
  logic [15:0] r_imm;
  logic [5:0]  r_leds;
  logic [31:0] r_uart;
  logic        r_write_uart;

  logic        w_imm_form;
  logic [6:0]  w_opcode;
  logic [1:0]  w_sel;
  logic [15:0] w_rd;
  logic        w_rd_we;
  logic [15:0] w_rd_val;
  logic        w_ac_we;
  logic [15:0] w_ac_val;
  logic        w_out;
  logic        w_prt;
  logic        w_jmp;
  logic [31:0] w_hex;
  logic        w_unused_ir_bits;

  assign w_imm_form       = r_ir[15];
  assign w_opcode         = r_ir[14:8];
  assign w_sel            = r_ir[1:0];
  assign w_unused_ir_bits = ^r_ir[7:2];

  assign flashReadAddr = r_addr;
  assign flashEnabled  = r_flash_en;
  assign leds          = r_leds;
  assign uartData      = {69'b0, r_uart};
  assign writeUart     = r_write_uart;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h37 + {4'h0, nib};  // 'A' - 10
  endfunction

  assign w_hex = {hex_ascii(r_ac[15:12]), hex_ascii(r_ac[11:8]),
                  hex_ascii(r_ac[7:4]),   hex_ascii(r_ac[3:0])};

  always_comb begin
    w_rd = r_ac;
    case (w_sel)
      2'd0:    w_rd = r_a;
      2'd1:    w_rd = r_b;
      2'd2:    w_rd = r_c;
      default: w_rd = r_ac;
    endcase
  end

  //--------------------------------------------------------------------------
  // State register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next_state;
  end

  //--------------------------------------------------------------------------
  // Next state. The WAIT_LOW states consume the tail of a ready pulse so a
  // long pulse can never deliver the same word twice.
  //--------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH:        w_next_state = S_WAIT_RDY;
      S_WAIT_RDY:     if (flashDataReady)  w_next_state = S_WAIT_LOW;
      S_WAIT_LOW:     if (!flashDataReady) w_next_state = S_DECODE;
      S_DECODE:       w_next_state = w_imm_form ? S_FETCH_IMM : S_EXEC;
      S_FETCH_IMM:    w_next_state = S_WAIT_RDY_IMM;
      S_WAIT_RDY_IMM: if (flashDataReady)  w_next_state = S_WAIT_LOW_IMM;
      S_WAIT_LOW_IMM: if (!flashDataReady) w_next_state = S_EXEC;
      S_EXEC:         w_next_state = S_FETCH;
      default:        w_next_state = S_FETCH;
    endcase
  end

  //--------------------------------------------------------------------------
  // Execute decode. An operation writes either Rd or AC, never both.
  // Unlisted opcode/flag combinations fall through as no-ops.
  //--------------------------------------------------------------------------
  always_comb begin
    w_rd_we  = 1'b0;
    w_rd_val = w_rd;
    w_ac_we  = 1'b0;
    w_ac_val = r_ac;
    w_out    = 1'b0;
    w_prt    = 1'b0;
    w_jmp    = 1'b0;
    if (r_state == S_EXEC) begin
      if (!w_imm_form) begin
        case (w_opcode)
          OP_CLR: begin w_rd_we = 1'b1; w_rd_val = 16'h0000;    end
          OP_ADD: begin w_ac_we = 1'b1; w_ac_val = r_ac + w_rd; end
          OP_STA: begin w_rd_we = 1'b1; w_rd_val = r_ac;        end
          OP_INV: begin w_rd_we = 1'b1; w_rd_val = ~w_rd;       end
          OP_LDA: begin w_ac_we = 1'b1; w_ac_val = w_rd;        end
          OP_OUT: w_out = 1'b1;
          OP_PRT: w_prt = 1'b1;
          OP_BTN: begin
            w_ac_we  = 1'b1;
            w_ac_val = {12'h000, ~btn4, ~btn3, ~btn2, ~btn1};
          end
          default: ;
        endcase
      end else begin
        case (w_opcode)
          OP_ADDI: begin w_ac_we = 1'b1; w_ac_val = r_ac + r_imm; end
          OP_LDI:  begin w_ac_we = 1'b1; w_ac_val = r_imm;        end
          OP_JMP:  w_jmp = 1'b1;
          default: ;
        endcase
      end
    end
  end

  //--------------------------------------------------------------------------
  // Datapath and registered outputs
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc         <= 24'h000000;
      r_addr       <= 24'h000000;
      r_flash_en   <= 1'b0;
      r_a          <= 16'h0000;
      r_b          <= 16'h0000;
      r_c          <= 16'h0000;
      r_ac         <= 16'h0000;
      r_ir         <= 16'h0000;
      r_imm        <= 16'h0000;
      r_leds       <= 6'h3F;
      r_uart       <= 32'h0000_0000;
      r_write_uart <= 1'b0;
    end else begin
      r_write_uart <= w_prt;

      case (r_state)
        S_FETCH, S_FETCH_IMM: begin
          r_addr     <= r_pc;
          r_flash_en <= 1'b1;
        end
        S_WAIT_RDY: begin
          if (flashDataReady) begin
            r_ir       <= flashByteRead;
            r_flash_en <= 1'b0;
            r_pc       <= r_pc + 24'd2;  // wraps naturally at 2^24
          end
        end
        S_WAIT_RDY_IMM: begin
          if (flashDataReady) begin
            r_imm      <= flashByteRead;
            r_flash_en <= 1'b0;
            r_pc       <= r_pc + 24'd2;
          end
        end
        default: ;
      endcase

      if (w_jmp) r_pc <= {8'h00, r_imm};

      if (w_rd_we) begin
        case (w_sel)
          2'd0:    r_a  <= w_rd_val;
          2'd1:    r_b  <= w_rd_val;
          2'd2:    r_c  <= w_rd_val;
          default: r_ac <= w_rd_val;
        endcase
      end
      if (w_ac_we) r_ac <= w_ac_val;

      if (w_out) r_leds <= ~r_ac[5:0];
      if (w_prt) r_uart <= w_hex;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu.sv
`default_nettype none
//============================================================================
// Module   : tb_cpu
// Purpose  : Self-checking bench for cpu: flash responder with random
//            latency, UART strobe monitor, directed scenarios and random
//            programs compared against a behavioural instruction model.
// Revision : 1.0 - initial release
//============================================================================
module tb_cpu;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [23:0]  flashReadAddr;
  logic [15:0]  flashByteRead;
  logic         flashEnabled;
  logic         flashDataReady;
  logic [5:0]   leds;
  logic [100:0] uartData;
  logic         writeUart;
  logic         btn1 = 1'b1;
  logic         btn2 = 1'b1;
  logic         btn3 = 1'b1;
  logic         btn4 = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [15:0]  mem [0:1023];
  logic [15:0]  prog [$];
  int           hold_cycles = 1;
  int           max_delay = 0;
  logic         stall_en = 1'b0;
  logic [23:0]  stall_addr = 24'h0;
  logic [23:0]  watch_addr = 24'h0;
  logic         hit = 1'b0;
  logic [23:0]  served [$];
  int           uart_pulses = 0;
  logic [100:0] uart_last = '0;

  logic [15:0]  m_reg [4];
  logic [5:0]   m_leds;
  logic [100:0] m_uart;
  int           m_prints;
  logic [23:0]  m_pc;

  cpu dut (
    .clk            (clk),
    .reset          (reset),
    .flashReadAddr  (flashReadAddr),
    .flashByteRead  (flashByteRead),
    .flashEnabled   (flashEnabled),
    .flashDataReady (flashDataReady),
    .leds           (leds),
    .uartData       (uartData),
    .writeUart      (writeUart),
    .btn1           (btn1),
    .btn2           (btn2),
    .btn3           (btn3),
    .btn4           (btn4)
  );

  always #5 clk = ~clk;

  // Flash responder: after a random delay, returns mem[addr/2] with ready
  // held for hold_cycles cycles.
  initial begin
    flashDataReady = 1'b0;
    flashByteRead  = 16'h0000;
    forever begin
      int d;
      @(negedge clk);
      if (!reset && flashEnabled && !(stall_en && flashReadAddr == stall_addr)) begin
        d = $urandom_range(max_delay, 0);
        repeat (d) @(negedge clk);
        if (!reset && flashEnabled) begin
          flashByteRead  = mem[flashReadAddr[10:1]];
          flashDataReady = 1'b1;
          served.push_back(flashReadAddr);
          if (flashReadAddr == watch_addr) hit = 1'b1;
          for (int i = 0; i < hold_cycles && !reset; i++) @(negedge clk);
          flashDataReady = 1'b0;
        end
      end
    end
  end

  // UART strobe monitor
  initial begin
    forever begin
      @(negedge clk);
      if (writeUart === 1'b1) begin
        uart_pulses++;
        uart_last = uartData;
      end
    end
  end

  task automatic load_mem;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h7F00;  // NOP filler
    for (int i = 0; i < prog.size(); i++) mem[i] = prog[i];
  endtask

  task automatic start_program(input int hold, input int dly, input logic [23:0] watch,
                               input logic stall, input logic [23:0] saddr);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    hold_cycles = hold;
    max_delay   = dly;
    watch_addr  = watch;
    stall_en    = stall;
    stall_addr  = saddr;
    hit         = 1'b0;
    served.delete();
    uart_pulses = 0;
    uart_last   = '0;
    reset = 1'b0;
  endtask

  task automatic wait_hit(input int budget);
    int n;
    n = 0;
    while (!hit && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL fetch_timeout: address %06h not fetched within %0d cycles", watch_addr, budget);
    end
  endtask

  // Behavioural model: straight-line execution of prog (no jumps).
  task automatic model_run;
    int i;
    logic [15:0] w;
    logic [15:0] imm;
    logic [6:0]  op;
    logic [1:0]  sel;
    string       s;
    for (int r = 0; r < 4; r++) m_reg[r] = 16'h0000;
    m_leds = 6'h3F; m_uart = '0; m_prints = 0; m_pc = 24'h0;
    i = 0;
    while (i < prog.size()) begin
      w = prog[i]; i++; m_pc += 24'd2; imm = 16'h0;
      if (w[15]) begin imm = prog[i]; i++; m_pc += 24'd2; end
      op = w[14:8]; sel = w[1:0];
      if (!w[15]) begin
        case (op)
          7'h00: m_reg[sel] = 16'h0000;
          7'h02: m_reg[3] = m_reg[3] + m_reg[sel];
          7'h04: m_reg[sel] = m_reg[3];
          7'h06: m_reg[sel] = ~m_reg[sel];
          7'h08: m_reg[3] = m_reg[sel];
          7'h0A: m_leds = ~m_reg[3][5:0];
          7'h0C: begin
            s = $sformatf("%04X", m_reg[3]);
            m_uart = {69'b0, s.getc(0), s.getc(1), s.getc(2), s.getc(3)};
            m_prints++;
          end
          7'h0E: m_reg[3] = {12'h000, ~btn4, ~btn3, ~btn2, ~btn1};
          default: ;
        endcase
      end else begin
        case (op)
          7'h02: m_reg[3] = m_reg[3] + imm;
          7'h08: m_reg[3] = imm;
          default: ;
        endcase
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (flashReadAddr !== 24'h0) begin errors++; $display("FAIL reset_addr: got %06h want 000000", flashReadAddr); end
    checks++; if (flashEnabled !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", flashEnabled); end
    checks++; if (leds !== 6'h3F) begin errors++; $display("FAIL reset_leds: got %b want 111111", leds); end
    checks++; if (uartData !== 101'h0) begin errors++; $display("FAIL reset_uart: got %h want 0", uartData); end
    checks++; if (writeUart !== 1'b0) begin errors++; $display("FAIL reset_wu: got %b want 0", writeUart); end
    checks++; if (dut.r_pc !== 24'h0) begin errors++; $display("FAIL reset_pc: got %06h want 000000", dut.r_pc); end
  endtask

  task automatic test_sequence;
    prog = '{16'h0002, 16'h0201, 16'h0402, 16'h0602, 16'h8200, 16'h0010};
    load_mem();
    start_program(2, 1, 24'd12, 1'b0, 24'h0);
    wait_hit(400);
    checks++; if (dut.r_c !== 16'hFFFF) begin errors++; $display("FAIL seq_c: got %04h want ffff", dut.r_c); end
    checks++; if (dut.r_ac !== 16'h0010) begin errors++; $display("FAIL seq_ac: got %04h want 0010", dut.r_ac); end
    checks++; if (dut.r_pc !== 24'd12) begin errors++; $display("FAIL seq_pc: got %0d want 12", dut.r_pc); end
    checks++; if (served.size() != 7) begin errors++; $display("FAIL seq_nfetch: got %0d want 7", served.size()); end
    for (int k = 0; k < 7 && k < served.size(); k++) begin
      checks++;
      if (served[k] !== 24'(2 * k)) begin errors++; $display("FAIL seq_addr%0d: got %0d want %0d", k, served[k], 2 * k); end
    end
  endtask

  task automatic test_long_ready;
    prog = '{16'h0600};  // INV A
    load_mem();
    start_program(10, 0, 24'd2, 1'b0, 24'h0);
    wait_hit(200);
    checks++; if (dut.r_a !== 16'hFFFF) begin errors++; $display("FAIL long_a: got %04h want ffff", dut.r_a); end
    checks++; if (dut.r_pc !== 24'd2) begin errors++; $display("FAIL long_pc: got %0d want 2", dut.r_pc); end
    checks++; if (served.size() != 2) begin errors++; $display("FAIL long_nfetch: got %0d want 2", served.size()); end
  endtask

  task automatic test_prt;
    prog = '{16'h8800, 16'h1234, 16'h0C00};
    load_mem();
    start_program(1, 2, 24'd6, 1'b0, 24'h0);
    wait_hit(300);
    checks++; if (uart_last !== {69'b0, 32'h31323334}) begin errors++; $display("FAIL prt_data: got %h want 31323334", uart_last); end
    checks++; if (uart_pulses != 1) begin errors++; $display("FAIL prt_pulses: got %0d want 1", uart_pulses); end
    repeat (3) @(negedge clk);
    checks++; if (uartData !== {69'b0, 32'h31323334}) begin errors++; $display("FAIL prt_hold: got %h want 31323334", uartData); end
  endtask

  task automatic test_out_addi;
    prog = '{16'h8800, 16'h002A, 16'h0A00, 16'h8800, 16'hFFFF, 16'h8200, 16'h0001};
    load_mem();
    start_program(1, 1, 24'd14, 1'b0, 24'h0);
    wait_hit(400);
    checks++; if (leds !== 6'b010101) begin errors++; $display("FAIL out_leds: got %b want 010101", leds); end
    checks++; if (dut.r_ac !== 16'h0000) begin errors++; $display("FAIL addi_wrap: got %04h want 0000", dut.r_ac); end
  endtask

  task automatic test_btn_jmp;
    btn2 = 1'b0;
    prog = '{16'h0E00, 16'h9000, 16'h0100};
    load_mem();
    start_program(1, 1, 24'h000100, 1'b0, 24'h0);
    wait_hit(300);
    checks++; if (dut.r_ac !== 16'h0002) begin errors++; $display("FAIL btn_ac: got %04h want 0002", dut.r_ac); end
    checks++; if (flashReadAddr !== 24'h000100) begin errors++; $display("FAIL jmp_addr: got %06h want 000100", flashReadAddr); end
    checks++; if (served.size() != 4) begin errors++; $display("FAIL jmp_nfetch: got %0d want 4", served.size()); end
    btn2 = 1'b1;
  endtask

  task automatic test_reset_mid;
    int n;
    prog = '{16'h8800, 16'h0015, 16'h0A00, 16'h0C00, 16'h8800, 16'hBEEF};
    load_mem();
    start_program(1, 1, 24'hFFFFFF, 1'b1, 24'd10);
    n = 0;
    while (!(flashEnabled === 1'b1 && flashReadAddr === 24'd10) && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++; if (n >= 400) begin errors++; $display("FAIL mid_reach: got timeout want imm wait at 10"); end
    checks++; if (leds !== 6'b101010) begin errors++; $display("FAIL mid_leds_pre: got %b want 101010", leds); end
    checks++; if (uart_pulses != 1) begin errors++; $display("FAIL mid_prt_pre: got %0d want 1", uart_pulses); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (flashEnabled !== 1'b0) begin errors++; $display("FAIL mid_en: got %b want 0", flashEnabled); end
    checks++; if (flashReadAddr !== 24'h0) begin errors++; $display("FAIL mid_addr: got %06h want 000000", flashReadAddr); end
    checks++; if (leds !== 6'h3F) begin errors++; $display("FAIL mid_leds: got %b want 111111", leds); end
    checks++; if (uartData !== 101'h0) begin errors++; $display("FAIL mid_uart: got %h want 0", uartData); end
    checks++; if (dut.r_ac !== 16'h0) begin errors++; $display("FAIL mid_ac: got %04h want 0000", dut.r_ac); end
    stall_en = 1'b0;
    @(negedge clk);
    served.delete();
    watch_addr = 24'h0;
    hit = 1'b0;
    reset = 1'b0;
    wait_hit(50);
    checks++;
    if (served.size() == 0 || served[0] !== 24'h0) begin
      errors++; $display("FAIL mid_restart: got %0d fetches want first fetch at 000000", served.size());
    end
  endtask

  task automatic test_random;
    int n;
    int kind;
    logic [15:0] w;
    logic [7:0]  low;
    for (int it = 0; it < 8; it++) begin
      prog.delete();
      n = $urandom_range(12, 5);
      for (int k = 0; k < n; k++) begin
        kind = $urandom_range(11, 0);
        low  = 8'($urandom);
        case (kind)
          8:       w = {1'b1, 7'h02, low};
          9:       w = {1'b1, 7'h08, low};
          10:      w = {1'b0, 7'h11, low};
          11:      w = {1'b1, 7'h00, low};
          default: w = {1'b0, 7'(2 * kind), low};
        endcase
        prog.push_back(w);
        if (w[15]) prog.push_back(16'($urandom));
      end
      {btn4, btn3, btn2, btn1} = 4'($urandom);
      load_mem();
      model_run();
      start_program($urandom_range(3, 1), 2, 24'(2 * prog.size()), 1'b0, 24'h0);
      wait_hit(3000);
      checks++; if (dut.r_a !== m_reg[0]) begin errors++; $display("FAIL rnd%0d_a: got %04h want %04h", it, dut.r_a, m_reg[0]); end
      checks++; if (dut.r_b !== m_reg[1]) begin errors++; $display("FAIL rnd%0d_b: got %04h want %04h", it, dut.r_b, m_reg[1]); end
      checks++; if (dut.r_c !== m_reg[2]) begin errors++; $display("FAIL rnd%0d_c: got %04h want %04h", it, dut.r_c, m_reg[2]); end
      checks++; if (dut.r_ac !== m_reg[3]) begin errors++; $display("FAIL rnd%0d_ac: got %04h want %04h", it, dut.r_ac, m_reg[3]); end
      checks++; if (leds !== m_leds) begin errors++; $display("FAIL rnd%0d_leds: got %b want %b", it, leds, m_leds); end
      checks++; if (uart_last !== m_uart) begin errors++; $display("FAIL rnd%0d_uart: got %h want %h", it, uart_last, m_uart); end
      checks++; if (uart_pulses != m_prints) begin errors++; $display("FAIL rnd%0d_prints: got %0d want %0d", it, uart_pulses, m_prints); end
      checks++; if (dut.r_pc !== m_pc) begin errors++; $display("FAIL rnd%0d_pc: got %0d want %0d", it, dut.r_pc, m_pc); end
    end
    {btn4, btn3, btn2, btn1} = 4'hF;
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_long_ready();
    test_prt();
    test_out_addi();
    test_btn_jmp();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
